edge_launch_tx: RTL and testbench
=================================

Name: edge_launch_tx

Overview:
- Transmit-side partner of the asynchronous edge detector.
- Converts single-cycle event strobes in the SYNC_CLK_IN domain into transitions on one toggle line, EDGE_OUT. Each accepted event produces exactly one edge.
- Consecutive edges are spaced by at least HOLD_CYCLES clocks, so a slower, unrelated receiver clock can resolve every edge.
- Events that arrive faster than the line can carry them are queued in a saturating pending counter, with sticky overflow reporting.

Parameters:
- HOLD_CYCLES, 4, minimum clocks between successive EDGE_OUT transitions; legal range 2..255.
- PEND_W, 4, width of the pending-event counter; capacity is 2^PEND_W-1 events.

Ports:
- SYNC_CLK_IN  in  1  sole clock, rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- EVENT_IN  in  1  single-cycle event strobe; each high cycle is one event.
- ENABLE_IN  in  1  when low, launches are suppressed; events are still counted.
- CLEAR_OVF_IN  in  1  clears OVERFLOW_OUT.
- EDGE_OUT  out  1  toggle line; every transition represents one event.
- BUSY_OUT  out  1  high while in HOLD.
- PENDING_OUT  out  PEND_W  count of queued events not yet launched.
- OVERFLOW_OUT  out  1  sticky: at least one event was dropped.

Behaviour:
- Reset (RESET_IN high at a rising edge) forces:
  - state IDLE;
  - EDGE_OUT=0, PENDING_OUT=0, OVERFLOW_OUT=0, BUSY_OUT=0;
  - hold counter=0.
- Reset mid-HOLD abandons the hold. If EDGE_OUT was 1, the forced return to 0 is itself seen as an edge by the receiver; this is accepted, and the receiver side must be reset together with this block.
- Pending counter (registered) per clock:
  - EVENT_IN and launch together: no change.
  - EVENT_IN only: +1, unless at 2^PEND_W-1, where the value holds and OVERFLOW_OUT sets.
  - Launch only: -1.
- A launch requires registered PENDING_OUT>0 and ENABLE_IN=1. An event arriving in the same cycle is not launched that cycle.
- Launch action:
  - EDGE_OUT toggles;
  - hold counter loads HOLD_CYCLES-1;
  - state goes to HOLD.
- IDLE:
  - launch condition true -> launch;
  - otherwise stay in IDLE.
- HOLD:
  - hold counter>0 -> decrement, stay in HOLD;
  - hold counter=0 and launch condition true -> launch (back-to-back, stays in HOLD);
  - hold counter=0 otherwise -> IDLE.
- Timing consequences:
  - Back-to-back edges are exactly HOLD_CYCLES clocks apart.
  - Latency from EVENT_IN sampled high at edge k, starting from idle with nothing pending: EDGE_OUT toggles at edge k+1.
- ENABLE_IN:
  - Deasserting mid-HOLD does not shorten or extend the hold.
  - While ENABLE_IN=0, the block parks in IDLE with pending retained.
  - Re-enabling resumes launches on the next clock.
- OVERFLOW_OUT:
  - Set only on a dropped event; never cleared by launches.
  - CLEAR_OVF_IN clears it on the next clock.
  - If clear and a new drop occur in the same cycle, set wins.
- BUSY_OUT is the registered decode of state==HOLD. PENDING_OUT is the counter register directly. All outputs are registered; there is no combinational path from any input.

Decomposition:
- Shared package edge_link_pkg holds:
  - the state enum {IDLE, HOLD};
  - HOLD_W = clog2(HOLD_CYCLES) as a function/constant;
  - the default values of HOLD_CYCLES and PEND_W, shared with the edge detector bench.
- One sub-module, sat_updown_counter: width-parameterised saturating up/down counter with inc, dec, count, and a dropped flag. It serves the pending counter.
- The FSM, hold counter and toggle flop stay in edge_launch_tx.

Test Plan (all cases HOLD_CYCLES=4, PEND_W=4):
- Reset, then a single EVENT_IN pulse at edge 10 -> EDGE_OUT 0->1 at edge 11; BUSY_OUT high edges 11-14; IDLE at edge 15; PENDING_OUT returns to 0 at edge 11.
- Three consecutive EVENT_IN cycles at edges 10-12 -> EDGE_OUT toggles at edges 11, 15, 19; PENDING_OUT peaks at 2; final EDGE_OUT=1.
- ENABLE_IN=0, then 20 events -> PENDING_OUT saturates at 15 and OVERFLOW_OUT=1. Set ENABLE_IN=1 -> exactly 15 toggles, 4 clocks apart; OVERFLOW_OUT stays 1 until CLEAR_OVF_IN pulses.
- At PENDING_OUT=15 with a launch occurring in the same cycle as EVENT_IN -> count stays 15, no overflow. CLEAR_OVF_IN coincident with a drop -> OVERFLOW_OUT=1.
- RESET_IN asserted two clocks into a HOLD with EDGE_OUT=1 and 3 pending -> next clock EDGE_OUT=0, PENDING_OUT=0, BUSY_OUT=0, no further toggles.
- Loopback into asynch_edge_detect: receiver clock period 128 ns, transmitter clock period 50 ns, HOLD_CYCLES=4, 50 random events -> receiver DETECT_OUT pulse count equals 50 minus the number of dropped events.

Source files
------------

// File: rtl/edge_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_link_pkg
// Purpose  : Shared types and defaults for the edge launch / edge detect link.
// Revision : 1.0 - initial release
// ============================================================================
package edge_link_pkg;

    localparam int c_def_hold_cycles = 4;
    localparam int c_def_pend_w      = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } link_state_e;

    // Width of a counter that must hold HOLD_CYCLES-1.
    function automatic int hold_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_updown_counter
// Purpose  : Saturating up/down counter; flags an increment lost at full scale.
// Revision : 1.0 - initial release
// ============================================================================
module sat_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_dropped
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    // Simultaneous inc and dec cancel, so a full counter can still accept one.
    always_comb begin
        w_count_d = r_count_q;
        o_dropped = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count_q == c_max) begin
                o_dropped = 1'b1;
            end else begin
                w_count_d = r_count_q + 1'b1;
            end
        end else if (i_dec && !i_inc && (r_count_q != '0)) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/edge_launch_tx.sv
`default_nettype none
// ============================================================================
// Module   : edge_launch_tx
// Purpose  : Turns event strobes into spaced transitions on one toggle line.
// Revision : 1.0 - initial release
// ============================================================================
module edge_launch_tx
    import edge_link_pkg::*;
#(
    parameter int HOLD_CYCLES = c_def_hold_cycles,
    parameter int PEND_W      = c_def_pend_w
) (
    input  logic              SYNC_CLK_IN,
    input  logic              RESET_IN,
    input  logic              EVENT_IN,
    input  logic              ENABLE_IN,
    input  logic              CLEAR_OVF_IN,
    output logic              EDGE_OUT,
    output logic              BUSY_OUT,
    output logic [PEND_W-1:0] PENDING_OUT,
    output logic              OVERFLOW_OUT
);

    localparam int                  c_hold_w    = hold_w(HOLD_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);

    link_state_e         r_state_q, w_state_d;
    logic [c_hold_w-1:0] r_hold_q,  w_hold_d;
    logic                r_edge_q,  w_edge_d;
    logic                r_busy_q,  w_busy_d;
    logic                r_ovf_q,   w_ovf_d;

    logic                w_launch;
    logic                w_dropped;
    logic [PEND_W-1:0]   w_pend;

    sat_updown_counter #(
        .WIDTH (PEND_W)
    ) u_pend_cnt (
        .clk       (SYNC_CLK_IN),
        .rst       (RESET_IN),
        .i_inc     (EVENT_IN),
        .i_dec     (w_launch),
        .o_count   (w_pend),
        .o_dropped (w_dropped)
    );

    // Launch uses the registered count only, so a same-cycle event waits a clock.
    assign w_launch = ENABLE_IN && (w_pend != '0) &&
                      ((r_state_q == IDLE) || (r_hold_q == '0));

    always_comb begin
        w_state_d = r_state_q;
        w_hold_d  = r_hold_q;
        w_edge_d  = r_edge_q;
        case (r_state_q)
            IDLE: begin
                if (w_launch) begin
                    w_edge_d  = ~r_edge_q;
                    w_hold_d  = c_hold_load;
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (r_hold_q != '0) begin
                    w_hold_d = r_hold_q - 1'b1;
                end else if (w_launch) begin
                    w_edge_d = ~r_edge_q;
                    w_hold_d = c_hold_load;
                end else begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        w_busy_d = (w_state_d == HOLD);
        // A fresh drop outranks a clear arriving in the same cycle.
        if (w_dropped) begin
            w_ovf_d = 1'b1;
        end else if (CLEAR_OVF_IN) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = r_ovf_q;
        end
    end

    always_ff @(posedge SYNC_CLK_IN) begin
        if (RESET_IN) begin
            r_state_q <= IDLE;
            r_hold_q  <= '0;
            r_edge_q  <= 1'b0;
            r_busy_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_hold_q  <= w_hold_d;
            r_edge_q  <= w_edge_d;
            r_busy_q  <= w_busy_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign EDGE_OUT     = r_edge_q;
    assign BUSY_OUT     = r_busy_q;
    assign PENDING_OUT  = w_pend;
    assign OVERFLOW_OUT = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_launch_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_launch_tx
// Purpose  : Directed self-checking bench for edge_launch_tx with rx loopback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_launch_tx;

    logic       clk = 1'b0;
    logic       rx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       edge_o;
    logic       busy;
    logic [3:0] pend;
    logic       ovf;

    int n_vec = 0;
    int n_err = 0;

    always #25 clk = ~clk;
    always #64 rx_clk = ~rx_clk;

    edge_launch_tx #(
        .HOLD_CYCLES (4),
        .PEND_W      (4)
    ) dut (
        .SYNC_CLK_IN  (clk),
        .RESET_IN     (rst),
        .EVENT_IN     (ev),
        .ENABLE_IN    (en),
        .CLEAR_OVF_IN (clr),
        .EDGE_OUT     (edge_o),
        .BUSY_OUT     (busy),
        .PENDING_OUT  (pend),
        .OVERFLOW_OUT (ovf)
    );

    // Receiver-side edge detector: two-flop synchroniser plus an edge flop.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   rx_cnt = 0;
    always_ff @(posedge rx_clk) begin
        s1 <= edge_o;
        s2 <= s1;
        s3 <= s2;
        if (s2 != s3) rx_cnt <= rx_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ev = 1'b0; en = 1'b1; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Reference model for the loopback run (ENABLE high, no clears).
    int m_pend = 0, m_hold = 0, m_busy = 0, m_drops = 0;

    task automatic step(input logic e);
        logic lm, dr;
        lm = (m_pend != 0) && ((m_busy == 0) || (m_hold == 0));
        dr = e && !lm && (m_pend == 15);
        if (e && !lm && m_pend < 15) m_pend++;
        else if (!e && lm) m_pend--;
        if (lm) begin m_hold = 3; m_busy = 1; end
        else if (m_busy != 0 && m_hold > 0) m_hold--;
        else m_busy = 0;
        if (dr) m_drops++;
        ev = e;
        tick();
        chk("lb_pend", pend, m_pend);
    endtask

    int exp_edge1 [14] = '{0,1,1,1,1,0,0,0,0,1,1,1,1,1};
    int exp_pend1 [14] = '{1,1,2,2,2,1,1,1,1,0,0,0,0,0};

    initial begin
        // ---- single event: latency and hold length
        @(negedge clk);
        do_reset();
        chk("rst_edge", edge_o, 0);
        chk("rst_pend", pend, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf",  ovf, 0);
        ev = 1'b1; tick(); ev = 1'b0;
        chk("s_pend_k", pend, 1);
        chk("s_edge_k", edge_o, 0);
        tick();
        chk("s_edge_k1", edge_o, 1);
        chk("s_pend_k1", pend, 0);
        chk("s_busy_k1", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_busy_hold", busy, 1);
        end
        tick();
        chk("s_busy_idle", busy, 0);
        chk("s_edge_idle", edge_o, 1);

        // ---- three back-to-back events
        do_reset();
        for (int c = 0; c < 14; c++) begin
            ev = (c < 3);
            tick();
            chk("b3_edge", edge_o, exp_edge1[c]);
            chk("b3_pend", pend, exp_pend1[c]);
        end
        ev = 1'b0;

        // ---- saturation while disabled, then drain
        do_reset();
        en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            ev = 1'b1; clr = (i == 18);
            tick();
            chk("sat_pend", pend, (i < 15) ? i : 15);
            if (i == 15) chk("sat_ovf15", ovf, 0);
            if (i >= 16) chk("sat_ovf", ovf, 1);
        end
        ev = 1'b0; clr = 1'b0; en = 1'b1;
        begin
            int last = -1, ntog = 0, bad = 0;
            logic prev;
            prev = edge_o;
            for (int c = 1; c <= 70; c++) begin
                tick();
                if (edge_o != prev) begin
                    ntog++;
                    if (ntog == 1) chk("drain_first", c, 1);
                    if (last >= 0 && (c - last) != 4) bad++;
                    last = c;
                    prev = edge_o;
                end
            end
            chk("drain_toggles", ntog, 15);
            chk("drain_spacing", bad, 0);
        end
        chk("drain_pend", pend, 0);
        chk("drain_busy", busy, 0);
        chk("drain_ovf_kept", ovf, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // ---- launch coincident with event at full count; clear vs drop
        do_reset();
        en = 1'b0;
        ev = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("full_pend", pend, 15);
        chk("full_ovf", ovf, 0);
        en = 1'b1;
        tick();
        chk("coinc_pend", pend, 15);
        chk("coinc_ovf", ovf, 0);
        chk("coinc_edge", edge_o, 1);
        chk("coinc_busy", busy, 1);
        clr = 1'b1;
        tick();
        chk("clr_drop_ovf", ovf, 1);
        chk("clr_drop_pend", pend, 15);
        ev = 1'b0; clr = 1'b0;

        // ---- reset two clocks into a hold
        do_reset();
        en = 1'b0; ev = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ev = 1'b0; en = 1'b1;
        tick();
        chk("mr_edge", edge_o, 1);
        chk("mr_pend", pend, 3);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_rst_edge", edge_o, 0);
        chk("mr_rst_pend", pend, 0);
        chk("mr_rst_busy", busy, 0);
        begin
            int ntog = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (edge_o != 1'b0) ntog++;
            end
            chk("mr_no_toggle", ntog, 0);
        end

        // ---- loopback into receiver model, 50 random events
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        begin
            int base;
            base = rx_cnt;
            m_pend = 0; m_hold = 0; m_busy = 0; m_drops = 0;
            for (int n = 0; n < 50; n++) begin
                int gap;
                gap = $urandom_range(0, 5);
                for (int g = 0; g < gap; g++) step(1'b0);
                step(1'b1);
            end
            for (int i = 0; i < 100; i++) step(1'b0);
            #1000;
            chk("lb_rx_count", rx_cnt - base, 50 - m_drops);
            chk("lb_ovf", ovf, (m_drops > 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
